// File: rtl/lfsr_step_engine.sv
// Galois LFSR step engine: synchronizes a 16-bit pad command bus, loads a seed,
// and advances the LFSR a commanded number of steps, exposing state[7:0] and busy.
module lfsr_step_engine #(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] TAPS     = 16'hB400,
  parameter int               STEP_DIV = 1
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic [15:0] cmd_i,
  output logic [7:0]  dout_o,
  output logic        busy_o,
  output logic        dbg_state_o
);

  localparam int DIVW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [1:0] OP_LOAD_LO = 2'b00;
  localparam logic [1:0] OP_LOAD_HI = 2'b01;
  localparam logic [1:0] OP_RUN     = 2'b10;
  localparam logic [1:0] OP_STOP    = 2'b11;

  state_e            r_fsm, w_fsm_nx;
  logic [15:0]       r_sync1, r_sync2;
  logic              r_strb_d;
  logic [WIDTH-1:0]  r_state, w_state_nx;
  logic [8:0]        r_left, w_left_nx;
  logic [DIVW-1:0]   r_div, w_div_nx;
  logic [7:0]        r_dout;

  logic              w_pulse;
  logic [1:0]        w_op;
  logic [7:0]        w_data;
  logic              w_div_wrap;
  logic [WIDTH-1:0]  w_stepped;
  logic [WIDTH-1:0]  w_load_val;
  logic              w_unused_bits;

  // Pulse fires on the first synchronized cycle the strobe reads high.
  assign w_pulse       = r_sync2[13] & ~r_strb_d;
  assign w_op          = r_sync2[15:14];
  assign w_data        = r_sync2[7:0];
  assign w_unused_bits = ^r_sync2[12:8];
  assign w_div_wrap    = (r_div == DIVW'(STEP_DIV - 1));
  assign w_stepped     = r_state[0] ? ((r_state >> 1) ^ TAPS) : (r_state >> 1);

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_strb_d <= 1'b0;
      r_fsm    <= IDLE;
      r_state  <= WIDTH'(1);
      r_left   <= '0;
      r_div    <= '0;
      r_dout   <= 8'h01;
    end else begin
      r_sync1  <= cmd_i;
      r_sync2  <= r_sync1;
      r_strb_d <= r_sync2[13];
      r_fsm    <= w_fsm_nx;
      r_state  <= w_state_nx;
      r_left   <= w_left_nx;
      r_div    <= w_div_nx;
      r_dout   <= r_state[7:0];
    end
  end

  always_comb begin
    w_fsm_nx   = r_fsm;
    w_state_nx = r_state;
    w_left_nx  = r_left;
    w_div_nx   = r_div;
    w_load_val = r_state;

    if (r_fsm == RUN) begin
      if (w_div_wrap) begin
        w_state_nx = w_stepped;
        w_left_nx  = r_left - 9'd1;
        w_div_nx   = '0;
        if (r_left == 9'd1) w_fsm_nx = IDLE;
      end else begin
        w_div_nx = r_div + DIVW'(1);
      end
    end

    // Busy is judged on the registered FSM, so a command landing on the
    // final step edge still sees RUN.
    if (w_pulse) begin
      case (w_op)
        OP_LOAD_LO, OP_LOAD_HI: begin
          if (r_fsm == IDLE) begin
            w_load_val = (w_op == OP_LOAD_LO) ? {r_state[WIDTH-1:8], w_data}
                                              : {w_data, r_state[7:0]};
            w_state_nx = (w_load_val == '0) ? WIDTH'(1) : w_load_val;
          end
        end
        OP_RUN: begin
          if (r_fsm == IDLE) begin
            w_fsm_nx  = RUN;
            w_left_nx = (w_data == 8'd0) ? 9'd256 : {1'b0, w_data};
            w_div_nx  = '0;
          end
        end
        OP_STOP: begin
          if (r_fsm == RUN) w_fsm_nx = IDLE;
        end
        default: ;
      endcase
    end
  end

  assign dout_o      = r_dout;
  assign busy_o      = (r_fsm == RUN);
  assign dbg_state_o = r_fsm;

endmodule
